// File: rtl/instr_encoder_pkg.sv
// rtl/instr_encoder_pkg.sv - shared op encoding, MIPS field constants and FSM states
// Contents:
//   op_e       symbolic operation select carried on in_op (30-31 undefined)
//   OP_* / FN_* MIPS primary opcodes and R-type function codes
//   state_e    encoder FSM states
//   r_word / i_word / j_word  field packers for the three MIPS formats
package instr_encoder_pkg;

  typedef enum logic [4:0] {
    INS_ADD   = 5'd0,
    INS_ADDU  = 5'd1,
    INS_SUB   = 5'd2,
    INS_SUBU  = 5'd3,
    INS_AND   = 5'd4,
    INS_OR    = 5'd5,
    INS_XOR   = 5'd6,
    INS_NOR   = 5'd7,
    INS_SLT   = 5'd8,
    INS_SLTU  = 5'd9,
    INS_SLL   = 5'd10,
    INS_SRL   = 5'd11,
    INS_SRA   = 5'd12,
    INS_SLLV  = 5'd13,
    INS_SRLV  = 5'd14,
    INS_SRAV  = 5'd15,
    INS_ADDI  = 5'd16,
    INS_ADDIU = 5'd17,
    INS_ANDI  = 5'd18,
    INS_ORI   = 5'd19,
    INS_XORI  = 5'd20,
    INS_LUI   = 5'd21,
    INS_LW    = 5'd22,
    INS_SW    = 5'd23,
    INS_BEQ   = 5'd24,
    INS_BNE   = 5'd25,
    INS_SLTI  = 5'd26,
    INS_SLTIU = 5'd27,
    INS_J     = 5'd28,
    INS_NOP   = 5'd29
  } op_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_SEAL = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] shamt,
                                         input logic [5:0] funct);
    return {OP_RTYPE, rs, rt, rd, shamt, funct};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] opc, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_word(input logic [25:0] target);
    return {OP_J, target};
  endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// rtl/instr_encoder_pack.sv - combinational op+fields to 32-bit MIPS word packer
// Module instr_pack ports:
//   op, rs, rt, rd, shamt, imm, target  symbolic request fields
//   word     packed instruction (0 when illegal)
//   illegal  op is not one of the defined encodings
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = 32'h0;
    illegal = 1'b0;
    case (op)
      // Register ALU ops and variable shifts carry no shift amount.
      INS_ADD:   word = r_word(rs, rt, rd, 5'd0, FN_ADD);
      INS_ADDU:  word = r_word(rs, rt, rd, 5'd0, FN_ADDU);
      INS_SUB:   word = r_word(rs, rt, rd, 5'd0, FN_SUB);
      INS_SUBU:  word = r_word(rs, rt, rd, 5'd0, FN_SUBU);
      INS_AND:   word = r_word(rs, rt, rd, 5'd0, FN_AND);
      INS_OR:    word = r_word(rs, rt, rd, 5'd0, FN_OR);
      INS_XOR:   word = r_word(rs, rt, rd, 5'd0, FN_XOR);
      INS_NOR:   word = r_word(rs, rt, rd, 5'd0, FN_NOR);
      INS_SLT:   word = r_word(rs, rt, rd, 5'd0, FN_SLT);
      INS_SLTU:  word = r_word(rs, rt, rd, 5'd0, FN_SLTU);
      // Shift-immediate ops do not read rs; the field must be zero.
      INS_SLL:   word = r_word(5'd0, rt, rd, shamt, FN_SLL);
      INS_SRL:   word = r_word(5'd0, rt, rd, shamt, FN_SRL);
      INS_SRA:   word = r_word(5'd0, rt, rd, shamt, FN_SRA);
      INS_SLLV:  word = r_word(rs, rt, rd, 5'd0, FN_SLLV);
      INS_SRLV:  word = r_word(rs, rt, rd, 5'd0, FN_SRLV);
      INS_SRAV:  word = r_word(rs, rt, rd, 5'd0, FN_SRAV);
      INS_ADDI:  word = i_word(OP_ADDI, rs, rt, imm);
      INS_ADDIU: word = i_word(OP_ADDIU, rs, rt, imm);
      INS_ANDI:  word = i_word(OP_ANDI, rs, rt, imm);
      INS_ORI:   word = i_word(OP_ORI, rs, rt, imm);
      INS_XORI:  word = i_word(OP_XORI, rs, rt, imm);
      INS_LUI:   word = i_word(OP_LUI, 5'd0, rt, imm);
      INS_LW:    word = i_word(OP_LW, rs, rt, imm);
      INS_SW:    word = i_word(OP_SW, rs, rt, imm);
      INS_BEQ:   word = i_word(OP_BEQ, rs, rt, imm);
      INS_BNE:   word = i_word(OP_BNE, rs, rt, imm);
      INS_SLTI:  word = i_word(OP_SLTI, rs, rt, imm);
      INS_SLTIU: word = i_word(OP_SLTIU, rs, rt, imm);
      INS_J:     word = j_word(target);
      INS_NOP:   word = 32'h0;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - packs symbolic instruction requests into imem words
// Ports:
//   clk, rst_n (async active-low), clear (sync restart)
//   in_valid/in_ready + in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target  request
//   seal           append self-jump terminator and stop
//   wr_en/wr_ready + wr_addr, wr_data   backpressured imem write port
//   count          words written since reset/clear
//   done           terminator written, block idle
//   err_illegal    sticky undefined-op flag
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int BASE   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              seal,
  output logic              wr_en,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              err_illegal
);

  state_e              state_q, state_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [31:0]         wr_data_q, wr_data_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                err_q, err_d;

  logic [31:0] pack_word;
  logic        pack_illegal;
  logic        wr_fire;
  logic        slot_free;
  logic        seal_go;
  logic        accept;

  instr_pack u_pack (
    .op      (in_op),
    .rs      (in_rs),
    .rt      (in_rt),
    .rd      (in_rd),
    .shamt   (in_shamt),
    .imm     (in_imm),
    .target  (in_target),
    .word    (pack_word),
    .illegal (pack_illegal)
  );

  assign wr_fire   = wr_en_q & wr_ready;
  // Output register can take a new word this cycle (empty or draining now).
  assign slot_free = !wr_en_q || wr_ready;
  assign seal_go   = (state_q == ST_LOAD) && seal && slot_free;
  assign accept    = in_valid & in_ready;

  // State register and datapath flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_LOAD;
      wr_en_q   <= 1'b0;
      wr_addr_q <= ADDR_W'(BASE);
      wr_data_q <= 32'h0;
      count_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      count_q   <= count_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD: if (seal_go) state_d = ST_SEAL;
      ST_SEAL: if (wr_fire) state_d = ST_DONE;
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_LOAD;
    endcase
    if (clear) state_d = ST_LOAD;
  end

  // Datapath next values.
  always_comb begin
    wr_en_d   = wr_en_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    count_d   = count_q;
    err_d     = err_q;

    if (wr_fire) begin
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q + ADDR_W'(1);
      count_d   = count_q + (ADDR_W+1)'(1);
    end

    if (seal_go) begin
      // Terminator jumps to its own address, i.e. the address after any
      // write completing this cycle.
      wr_en_d   = 1'b1;
      wr_data_d = j_word(26'(wr_addr_d));
    end else if (accept) begin
      if (pack_illegal) begin
        err_d = 1'b1;
      end else begin
        wr_en_d   = 1'b1;
        wr_data_d = pack_word;
      end
    end

    if (clear) begin
      wr_en_d   = 1'b0;
      wr_addr_d = ADDR_W'(BASE);
      wr_data_d = 32'h0;
      count_d   = '0;
      err_d     = 1'b0;
    end
  end

  // Outputs. The occupancy test keeps the final slot free for the terminator.
  always_comb begin
    in_ready = rst_n && (state_q == ST_LOAD) && !seal && slot_free &&
               ((int'(count_q) + int'(wr_en_q)) < (DEPTH - 1));
    done     = (state_q == ST_DONE);
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign count       = count_q;
  assign err_illegal = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed self-checking bench for instr_encoder
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_op;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [4:0]        in_shamt;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              seal;
  logic              wr_en;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [ADDR_W:0]   count;
  logic              done;
  logic              err_illegal;

  int n_checks = 0;
  int n_fails  = 0;

  instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE(0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_rs       (in_rs),
    .in_rt       (in_rt),
    .in_rd       (in_rd),
    .in_shamt    (in_shamt),
    .in_imm      (in_imm),
    .in_target   (in_target),
    .seal        (seal),
    .wr_en       (wr_en),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .count       (count),
    .done        (done),
    .err_illegal (err_illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm);
    in_valid = 1'b1;
    in_op    = op;
    in_rs    = rs;
    in_rt    = rt;
    in_rd    = rd;
    in_shamt = sh;
    in_imm   = imm;
  endtask

  task automatic do_clear();
    in_valid = 1'b0;
    clear    = 1'b1;
    step();
    clear    = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b1; in_op = 5'd0; in_rs = 5'd0;
    in_rt = 5'd0; in_rd = 5'd0; in_shamt = 5'd0; in_imm = 16'h0; in_target = 26'h0;
    seal = 1'b0; wr_ready = 1'b1;
    step();
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", wr_data, 32'h0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err_illegal), 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    step();

    // ADD rd=3 rs=1 rt=2
    req(INS_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0);
    #1 chk("add_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("add_wr_en", 32'(wr_en), 32'd1);
    chk("add_wr_addr", 32'(wr_addr), 32'd0);
    chk("add_wr_data", wr_data, 32'h00221820);
    step();
    chk("add_count", 32'(count), 32'd1);
    chk("add_wr_en_off", 32'(wr_en), 32'd0);
    chk("add_addr_inc", 32'(wr_addr), 32'd1);
    do_clear();
    chk("clr1_count", 32'(count), 32'd0);
    chk("clr1_addr", 32'(wr_addr), 32'd0);

    // LW then BEQ back-to-back
    req(INS_LW, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004);
    step();
    chk("lw_data", wr_data, 32'h8FA80004);
    chk("lw_addr", 32'(wr_addr), 32'd0);
    req(INS_BEQ, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF);
    #1 chk("beq_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("beq_wr_en", 32'(wr_en), 32'd1);
    chk("beq_data", wr_data, 32'h1022FFFF);
    chk("beq_addr", 32'(wr_addr), 32'd1);
    chk("beq_count", 32'(count), 32'd1);
    step();
    chk("b2b_count", 32'(count), 32'd2);
    do_clear();

    // Backpressure: ADDI pending, ORI waiting
    wr_ready = 1'b0;
    req(INS_ADDI, 5'd0, 5'd1, 5'd0, 5'd0, 16'h0005);
    step();
    req(INS_ORI, 5'd1, 5'd2, 5'd0, 5'd0, 16'h00FF);
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_in_ready", 32'(in_ready), 32'd0);
      step();
      chk("stall_wr_en", 32'(wr_en), 32'd1);
      chk("stall_data", wr_data, 32'h20010005);
      chk("stall_addr", 32'(wr_addr), 32'd0);
      chk("stall_count", 32'(count), 32'd0);
    end
    wr_ready = 1'b1;
    #1 chk("release_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("release_data", wr_data, 32'h342200FF);
    chk("release_addr", 32'(wr_addr), 32'd1);
    chk("release_count", 32'(count), 32'd1);
    step();
    chk("release_count2", 32'(count), 32'd2);
    do_clear();

    // Illegal op
    req(5'd30, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0);
    #1 chk("ill_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("ill_wr_en", 32'(wr_en), 32'd0);
    chk("ill_err", 32'(err_illegal), 32'd1);
    step();
    chk("ill_err_sticky", 32'(err_illegal), 32'd1);
    chk("ill_count", 32'(count), 32'd0);
    do_clear();
    chk("ill_clr_err", 32'(err_illegal), 32'd0);
    chk("ill_clr_count", 32'(count), 32'd0);

    // Fill to DEPTH-1, then seal
    req(INS_SUB, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0);
    step();
    req(INS_NOP, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0);
    step();
    chk("fill_nop_data", wr_data, 32'h0);
    req(INS_SW, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0008);
    step();
    chk("fill_sw_data", wr_data, 32'hAFA80008);
    #1 chk("full_in_ready_pend", 32'(in_ready), 32'd0);
    step();
    chk("full_count", 32'(count), 32'd3);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    seal = 1'b1;
    step();
    chk("seal_wr_en", 32'(wr_en), 32'd1);
    chk("seal_data", wr_data, 32'h08000003);
    chk("seal_addr", 32'(wr_addr), 32'd3);
    seal = 1'b0;
    step();
    chk("done", 32'(done), 32'd1);
    chk("done_count", 32'(count), 32'd4);
    chk("done_wr_en", 32'(wr_en), 32'd0);
    in_valid = 1'b1;
    #1 chk("done_in_ready", 32'(in_ready), 32'd0);
    do_clear();
    chk("clr_done", 32'(done), 32'd0);

    // Seal wins over a simultaneous request
    req(INS_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0);
    seal = 1'b1;
    #1 chk("seal_wins_ready", 32'(in_ready), 32'd0);
    step();
    seal = 1'b0;
    in_valid = 1'b0;
    chk("seal_wins_data", wr_data, 32'h08000000);
    step();
    do_clear();

    // SLL forces rs=0; async reset mid-stall
    wr_ready = 1'b0;
    req(INS_SLL, 5'd7, 5'd5, 5'd4, 5'd2, 16'h0);
    step();
    in_valid = 1'b0;
    chk("sll_data", wr_data, 32'h00052080);
    step();
    chk("sll_stall_en", 32'(wr_en), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_wr_en", 32'(wr_en), 32'd0);
    chk("async_rst_data", wr_data, 32'h0);
    step();
    rst_n = 1'b1;
    wr_ready = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
